// File: rtl/pattern_detector.sv
// Runtime-programmable serial bit-pattern detector.
// Accepts one qualified serial bit per cycle, compares the most recent
// cur_len bits against a loaded pattern and produces a registered one-cycle
// detect pulse plus a saturating match counter. Overlapping and
// non-overlapping detection are selectable at configuration time.
module pattern_detector #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                cfg_load,
    input  logic [MAX_LEN-1:0]  cfg_pattern,
    input  logic [LEN_W-1:0]    cfg_len,
    input  logic                cfg_overlap,
    input  logic                in_valid,
    input  logic                sequence_in,
    input  logic                clear_count,
    output logic                detect,
    output logic [CNT_W-1:0]    match_count,
    output logic                cfg_err,
    output logic [LEN_W-1:0]    cur_len
);

    localparam logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(4'b1011);
    localparam logic [LEN_W-1:0]   RST_LEN     = LEN_W'(3'd4);
    localparam logic [LEN_W-1:0]   FULL_LEN    = LEN_W'(MAX_LEN);
    localparam logic [CNT_W-1:0]   CNT_MAX     = {CNT_W{1'b1}};

    // Mask with the low 'len' bits set; bits above len-1 take no part in the compare.
    function automatic logic [MAX_LEN-1:0] len_mask(input logic [LEN_W-1:0] len);
        logic [MAX_LEN-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            m[i] = (LEN_W'(i) < len);
        end
        return m;
    endfunction

    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               overlap_q, overlap_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               detect_q, detect_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               cfg_err_q, cfg_err_d;
    logic               match_s;
    logic               len_ok_s;
    logic [MAX_LEN-1:0] mask_s;

    // Next-state: configuration load, bit accept, match evaluation and counter.
    always_comb begin
        pattern_d = pattern_q;
        len_d     = len_q;
        overlap_d = overlap_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        detect_d  = 1'b0;
        cfg_err_d = 1'b0;
        count_d   = count_q;
        match_s   = 1'b0;
        len_ok_s  = (cfg_len != '0) && (cfg_len <= FULL_LEN);
        mask_s    = len_mask(len_q);

        if (cfg_load) begin
            // A bit offered alongside a load is dropped either way.
            if (len_ok_s) begin
                pattern_d = cfg_pattern;
                len_d     = cfg_len;
                overlap_d = cfg_overlap;
                fill_d    = '0;
            end else begin
                cfg_err_d = 1'b1;
            end
        end else if (in_valid) begin
            hist_d = {hist_q[MAX_LEN-2:0], sequence_in};
            fill_d = (fill_q == FULL_LEN) ? fill_q : fill_q + LEN_W'(1'b1);
            // fill guarantees only bits accepted since the last restart are compared.
            match_s = (fill_d >= len_q) && ((hist_d & mask_s) == (pattern_q & mask_s));
            if (match_s) begin
                detect_d = 1'b1;
                if (!overlap_q) begin
                    fill_d = '0;
                end else begin
                    fill_d = fill_d;
                end
            end else begin
                detect_d = 1'b0;
            end
        end else begin
            hist_d = hist_q;
        end

        if (clear_count) begin
            count_d = '0;
        end else if (match_s && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_W'(1'b1);
        end else begin
            count_d = count_q;
        end
    end

    // State and output registers with asynchronous reset to the default configuration.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pattern_q <= RST_PATTERN;
            len_q     <= RST_LEN;
            overlap_q <= 1'b1;
            hist_q    <= '0;
            fill_q    <= '0;
            detect_q  <= 1'b0;
            count_q   <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            pattern_q <= pattern_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            detect_q  <= detect_d;
            count_q   <= count_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign detect      = detect_q;
    assign match_count = count_q;
    assign cfg_err     = cfg_err_q;
    assign cur_len     = len_q;

endmodule

// File: tb/tb_pattern_detector.sv
// Directed bench for pattern_detector: a queue-based reference model checked
// every cycle, plus literal expectations at the key points of each scenario.
module tb_pattern_detector;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 2;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               cfg_load = 1'b0;
    logic [MAX_LEN-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0]   cfg_len = '0;
    logic               cfg_overlap = 1'b0;
    logic               in_valid = 1'b0;
    logic               sequence_in = 1'b0;
    logic               clear_count = 1'b0;
    logic               detect;
    logic [CNT_W-1:0]   match_count;
    logic               cfg_err;
    logic [LEN_W-1:0]   cur_len;

    int errors = 0;
    int checks = 0;
    bit run = 1'b0;

    pattern_detector #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid),
        .sequence_in(sequence_in), .clear_count(clear_count), .detect(detect),
        .match_count(match_count), .cfg_err(cfg_err), .cur_len(cur_len)
    );

    initial forever #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: 'fresh' holds bits accepted since the last restart.
    logic [7:0] m_pat;
    int         m_len;
    bit         m_ovl;
    bit         fresh[$];
    int         m_cnt;
    bit         m_det;
    bit         m_err;

    always @(posedge clock or posedge reset) begin
        bit hit;
        hit = 1'b0;
        if (reset) begin
            m_pat = 8'b0000_1011; m_len = 4; m_ovl = 1'b1;
            fresh.delete(); m_cnt = 0; m_det = 1'b0; m_err = 1'b0;
        end else begin
            m_det = 1'b0; m_err = 1'b0;
            if (cfg_load) begin
                if (cfg_len >= 1 && cfg_len <= MAX_LEN) begin
                    m_pat = cfg_pattern; m_len = int'(cfg_len); m_ovl = cfg_overlap;
                    fresh.delete();
                end else begin
                    m_err = 1'b1;
                end
            end else if (in_valid) begin
                fresh.push_back(sequence_in);
                if (fresh.size() >= m_len) begin
                    hit = 1'b1;
                    for (int k = 0; k < m_len; k++)
                        if (fresh[fresh.size() - 1 - k] != m_pat[k]) hit = 1'b0;
                end
                if (hit) begin
                    m_det = 1'b1;
                    if (!m_ovl) fresh.delete();
                end
                if (fresh.size() > MAX_LEN) void'(fresh.pop_front());
            end
            if (clear_count) m_cnt = 0;
            else if (hit && m_cnt < CMAX) m_cnt++;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clock) begin
        if (run && !reset) begin
            chk("cyc_detect", int'(detect), int'(m_det));
            chk("cyc_count", int'(match_count), m_cnt);
            chk("cyc_cfg_err", int'(cfg_err), int'(m_err));
            chk("cyc_cur_len", int'(cur_len), m_len);
        end
    end

    task automatic step(input bit v, input bit b, input bit clr);
        cfg_load = 1'b0; in_valid = v; sequence_in = b; clear_count = clr;
        @(negedge clock);
    endtask

    // Feed n bits, bits[n-1] first.
    task automatic feed(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i], 1'b0);
    endtask

    task automatic cfg(input logic [7:0] p, input int l, input bit o, input bit v, input bit b);
        cfg_load = 1'b1; cfg_pattern = p; cfg_len = LEN_W'(l); cfg_overlap = o;
        in_valid = v; sequence_in = b; clear_count = 1'b0;
        @(negedge clock);
        cfg_load = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clock);
        reset = 1'b0;
        run = 1'b1;
        chk("rst_detect", int'(detect), 0);
        chk("rst_count", int'(match_count), 0);
        chk("rst_cfg_err", int'(cfg_err), 0);
        chk("rst_cur_len", int'(cur_len), 4);

        // Default pattern 1011 with overlap.
        feed(16'b101, 3);       chk("def_no_early", int'(detect), 0);
        feed(16'b1, 1);         chk("def_det4", int'(detect), 1);
        feed(16'b0, 1);         chk("def_gap5", int'(detect), 0);
        feed(16'b11, 2);        chk("def_det7", int'(detect), 1);
        chk("def_count2", int'(match_count), 2);
        step(1'b0, 1'b0, 1'b1); chk("clear", int'(match_count), 0);

        // Non-overlapping 110.
        cfg(8'b110, 3, 1'b0, 1'b0, 1'b0);
        chk("cur_len3", int'(cur_len), 3);
        feed(16'b110, 3);       chk("no_ov_det3", int'(detect), 1);
        feed(16'b11, 2);        chk("no_ov_bit5", int'(detect), 0);
        feed(16'b0, 1);         chk("no_ov_det6", int'(detect), 1);
        feed(16'b110, 3);       chk("no_ov_det9", int'(detect), 1);
        chk("count3", int'(match_count), 3);

        // Overlapping 11; counter saturates.
        cfg(8'b11, 2, 1'b1, 1'b0, 1'b0);
        feed(16'b1, 1);         chk("ov_bit1", int'(detect), 0);
        feed(16'b1, 1);         chk("ov_det2", int'(detect), 1);
        feed(16'b1, 1);         chk("ov_det3", int'(detect), 1);
        chk("sat_count", int'(match_count), 3);
        step(1'b0, 1'b0, 1'b1);

        // Gaps in in_valid with the default pattern.
        cfg(8'b1011, 4, 1'b1, 1'b0, 1'b0);
        feed(16'b10, 2);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0); chk("gap_idle", int'(detect), 0);
        end
        feed(16'b1, 1);         chk("gap_bit3", int'(detect), 0);
        feed(16'b1, 1);         chk("gap_det", int'(detect), 1);

        // Clear coinciding with a match.
        feed(16'b01, 2);
        step(1'b1, 1'b1, 1'b1);
        chk("clr_win_det", int'(detect), 1);
        chk("clr_win_cnt", int'(match_count), 0);

        // Rejected configurations.
        cfg(8'hFF, 0, 1'b0, 1'b1, 1'b0);
        chk("err_len0", int'(cfg_err), 1);
        chk("err_len0_cur", int'(cur_len), 4);
        step(1'b0, 1'b0, 1'b0); chk("err_pulse_end", int'(cfg_err), 0);
        cfg(8'hFF, 9, 1'b0, 1'b1, 1'b1);
        chk("err_len9", int'(cfg_err), 1);
        chk("err_len9_cur", int'(cur_len), 4);
        feed(16'b1011, 4);      chk("err_still_def", int'(detect), 1);

        // Load and valid bit in the same cycle: the bit is dropped.
        cfg(8'b1011, 4, 1'b1, 1'b1, 1'b1);
        feed(16'b011, 3);       chk("drop_bit", int'(detect), 0);

        // Full-length pattern A5, non-overlapping.
        cfg(8'hA5, 8, 1'b0, 1'b0, 1'b0);
        chk("cur_len8", int'(cur_len), 8);
        feed(16'b1010010, 7);   chk("a5_bit7", int'(detect), 0);
        feed(16'b1, 1);         chk("a5_det8", int'(detect), 1);

        // Reset mid-pattern restores defaults and needs a fresh pattern.
        feed(16'b101, 3);
        reset = 1'b1;
        @(negedge clock);
        chk("mid_rst_det", int'(detect), 0);
        chk("mid_rst_cnt", int'(match_count), 0);
        chk("mid_rst_len", int'(cur_len), 4);
        reset = 1'b0;
        feed(16'b1, 1);         chk("post_rst_1", int'(detect), 0);
        feed(16'b011, 3);       chk("post_rst_det", int'(detect), 1);

        // Reset kills an in-flight detect pulse.
        feed(16'b01, 2);
        in_valid = 1'b1; sequence_in = 1'b1;
        @(posedge clock);
        #1;
        chk("inflight_det", int'(detect), 1);
        reset = 1'b1;
        #1;
        chk("inflight_rst_det", int'(detect), 0);
        chk("inflight_rst_cnt", int'(match_count), 0);
        in_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        step(1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pattern_detector.md
Name: pattern_detector

Overview:
- Runtime-programmable serial bit-pattern detector; generalises the fixed 4-bit Moore detector.
- Pattern length is configurable from 1 to MAX_LEN bits, loaded at run time.
- Selectable overlapping or non-overlapping detection, plus a saturating match counter.
- Sits between a serial bit source (with a valid qualifier) and status/interrupt logic.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (legal range 2..16).
- CNT_W, 8, width of the match counter.
- LEN_W, $clog2(MAX_LEN+1), width of the length fields (derived; do not override).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- cfg_load  in  1  one-cycle strobe that latches the cfg_* inputs.
- cfg_pattern  in  MAX_LEN  pattern bits; bit [len-1] is received first, bit [0] last.
- cfg_len  in  LEN_W  pattern length.
- cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- in_valid  in  1  qualifies sequence_in for the current cycle.
- sequence_in  in  1  serial data bit.
- clear_count  in  1  synchronous clear of match_count.
- detect  out  1  one-cycle match pulse (registered).
- match_count  out  CNT_W  saturating count of detections.
- cfg_err  out  1  one-cycle pulse when a cfg_load is rejected.
- cur_len  out  LEN_W  currently active pattern length.

Behaviour:
- Reset values:
  - pattern = 'b1011 (zero-extended), length = 4, overlap = 1.
  - history = 0, fill = 0.
  - detect = 0, match_count = 0, cfg_err = 0, cur_len = 4.
- State:
  - history shift register, MAX_LEN bits.
  - fill counter, saturates at MAX_LEN.
  - active pattern, length and overlap registers.
- Bit accept: on a clock edge with in_valid=1 and cfg_load=0:
  - history <= {history[MAX_LEN-2:0], sequence_in}, so history[0] holds the newest bit.
  - fill <= min(fill+1, MAX_LEN).
- in_valid=0: history, fill and counter hold. detect is 0 in the following cycle.
- Match condition, evaluated on the post-shift value:
  - fill_next >= len, and
  - history_next[len-1:0] == pattern[len-1:0].
  - Bits above len-1 are masked out of the compare.
- Detect timing: detect goes high for exactly one cycle, in the cycle after the edge that accepted the completing bit (Moore-style, latency 1). It is never combinational from sequence_in.
- Overlap=1: fill is not disturbed by a match, so a suffix of one match may begin the next.
- Overlap=0: on a match, fill is forced to 0 and history is left as is. The next match needs len fresh accepted bits.
- match_count:
  - Increments by 1 on each match and saturates at 2^CNT_W-1 (no wrap).
  - clear_count sets it to 0.
  - If clear_count coincides with a match, the result is 0 (clear wins).
- cfg_load with 1 <= cfg_len <= MAX_LEN:
  - Latches pattern, length and overlap.
  - Sets fill to 0 and suppresses detect next cycle.
  - match_count is unchanged.
  - A sequence_in bit presented in the same cycle is discarded (cfg_load wins).
- cfg_load with cfg_len = 0 or cfg_len > MAX_LEN:
  - Configuration, history and fill are unchanged.
  - cfg_err pulses high for one cycle.
  - The in_valid bit in that cycle is also discarded.
- cur_len reflects the active length register; it updates the cycle after a successful load.
- Length 1: every accepted bit equal to pattern[0] produces a detect.
- Reset asserted mid-stream: all state returns immediately to reset values, including an in-flight detect pulse.

Test Plan:
- Defaults after reset, stream 1,0,1,1,0,1,1 on consecutive valid cycles -> detect high the cycle after the 4th bit and after the 7th bit (overlap); match_count = 2.
- Load pattern 'b110, len 3, overlap 0; stream 1,1,0,1,1,0,1,1,0 -> three detects, one cycle after bits 3, 6 and 9. Then load overlap=1, len 2, pattern 'b11; stream 1,1,1 -> detects after bits 2 and 3.
- Gaps: default pattern 1,0,(in_valid=0 for 3 cycles),1,1 -> single detect one cycle after the final valid bit; no detect during the gap.
- Saturation/clear with CNT_W=2: 5 matches -> match_count stays 3. clear_count together with a match -> 0 next cycle.
- Config errors: cfg_load with cfg_len = 0, then cfg_len = 9 (MAX_LEN=8) -> cfg_err pulses each time; cur_len stays 4; default pattern still detected.
- Boundaries: cfg_load and in_valid in the same cycle -> bit dropped and fill = 0. len = MAX_LEN pattern 'hA5 -> detect only after 8 valid bits. Reset asserted mid-pattern -> detect = 0, match_count = 0, and a full fresh pattern is needed.
